// File: rtl/id_ctrl_stage.sv
// ID-stage control decoder with ARM condition evaluation, registered into the ID/EX control word.
// A multi-cycle MUL holds EX via a busy FSM; freeze holds the register and flush kills it.
module id_ctrl_stage #(
  parameter int unsigned      CMD_W   = 4,
  parameter int unsigned      MUL_LAT = 3,
  parameter logic [CMD_W-1:0] MUL_CMD = CMD_W'(4'b1010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       cond,
  input  logic [3:0]       op_code,
  input  logic [1:0]       mode,
  input  logic             S_in,
  input  logic             is_mul,
  input  logic [3:0]       status,
  input  logic             freeze,
  input  logic             flush,
  output logic             out_valid,
  output logic             S_out,
  output logic             B,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT) + 1;

  typedef struct packed {
    logic             valid;
    logic             s;
    logic             b;
    logic             mem_r;
    logic             mem_w;
    logic             wb;
    logic [CMD_W-1:0] cmd;
  } ctrl_t;

  typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              ctrl_q, ctrl_d;
  ctrl_t              dec;
  logic               dec_is_mul;
  logic               cond_pass;
  logic               issue;

  // Decode opcode/mode/S into an EX control word (valid assumed; gated later)
  always_comb begin
    dec        = '0;
    dec_is_mul = 1'b0;
    if (mode == 2'b10) begin
      dec.b = ~op_code[3];
    end else if (mode == 2'b00 && is_mul) begin
      dec.cmd    = MUL_CMD;
      dec.wb     = 1'b1;
      dec_is_mul = 1'b1;
    end else begin
      case (op_code)
        4'b1101: begin dec.cmd = CMD_W'(4'b0001); dec.wb = 1'b1; end
        4'b1111: begin dec.cmd = CMD_W'(4'b1001); dec.wb = 1'b1; end
        4'b0100: begin
          if (mode == 2'b00) begin
            dec.cmd = CMD_W'(4'b0010);
            dec.wb  = 1'b1;
          end else if (mode == 2'b01) begin
            dec.cmd   = CMD_W'(4'b0010);
            dec.wb    = S_in;
            dec.mem_r = S_in;
            dec.mem_w = ~S_in;
          end
        end
        4'b0101: begin dec.cmd = CMD_W'(4'b0011); dec.wb = 1'b1; end
        4'b0010: begin dec.cmd = CMD_W'(4'b0100); dec.wb = 1'b1; end
        4'b0110: begin dec.cmd = CMD_W'(4'b0101); dec.wb = 1'b1; end
        4'b0000: begin dec.cmd = CMD_W'(4'b0110); dec.wb = 1'b1; end
        4'b1100: begin dec.cmd = CMD_W'(4'b0111); dec.wb = 1'b1; end
        4'b0001: begin dec.cmd = CMD_W'(4'b1000); dec.wb = 1'b1; end
        4'b1010: dec.cmd = CMD_W'(4'b0100);
        4'b1000: dec.cmd = CMD_W'(4'b0110);
        default: ;
      endcase
    end
    dec.s     = (mode == 2'b00) & S_in;
    dec.valid = 1'b1;
  end

  // Condition field against {N,Z,C,V}
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = status;
    unique case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign issue = in_valid & cond_pass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Priority: flush > freeze > FSM state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      ctrl_d  = '0;
    end else if (!freeze) begin
      unique case (state_q)
        StIdle: begin
          ctrl_d = issue ? dec : '0;
          if (issue && dec_is_mul && (MUL_LAT > 1)) begin
            state_d = StMulBusy;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end
        end
        StMulBusy: begin
          ctrl_d = '0;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid = ctrl_q.valid;
    S_out     = ctrl_q.s;
    B         = ctrl_q.b;
    mem_r_en  = ctrl_q.mem_r;
    mem_w_en  = ctrl_q.mem_w;
    wb_en     = ctrl_q.wb;
    exe_cmd   = ctrl_q.cmd;
    busy      = (state_q == StMulBusy);
  end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode/condition vector table plus MUL, freeze,
// flush, reset and MUL_LAT=1 sequences.
module tb_id_ctrl_stage;

  logic       clk, rst;
  logic       in_valid, S_in, is_mul, freeze, flush;
  logic [3:0] cond, op_code, status;
  logic [1:0] mode;

  logic       ov1, s1, b1, mr1, mw1, wb1, busy1;
  logic [3:0] cmd1;
  logic       ov2, s2, b2, mr2, mw2, wb2, busy2;
  logic [5:0] cmd2;

  int n_checks = 0;
  int n_pass   = 0;

  id_ctrl_stage #(.CMD_W(4), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cond(cond), .op_code(op_code),
    .mode(mode), .S_in(S_in), .is_mul(is_mul), .status(status), .freeze(freeze),
    .flush(flush), .out_valid(ov1), .S_out(s1), .B(b1), .mem_r_en(mr1),
    .mem_w_en(mw1), .wb_en(wb1), .exe_cmd(cmd1), .busy(busy1)
  );

  id_ctrl_stage #(.CMD_W(6), .MUL_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cond(cond), .op_code(op_code),
    .mode(mode), .S_in(S_in), .is_mul(is_mul), .status(status), .freeze(freeze),
    .flush(flush), .out_valid(ov2), .S_out(s2), .B(b2), .mem_r_en(mr2),
    .mem_w_en(mw2), .wb_en(wb2), .exe_cmd(cmd2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       iv;
    logic [3:0] cnd;
    logic [3:0] op;
    logic [1:0] md;
    logic       s;
    logic [3:0] st;
    logic [9:0] exp;  // {valid, S, B, mem_r, mem_w, wb, cmd[3:0]}
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic iv, logic [3:0] cnd, logic [3:0] op, logic [1:0] md,
                              logic s, logic [3:0] st, logic [9:0] exp);
    vec_t v;
    v.iv = iv; v.cnd = cnd; v.op = op; v.md = md; v.s = s; v.st = st; v.exp = exp;
    return v;
  endfunction

  function automatic logic [9:0] word1();
    return {ov1, s1, b1, mr1, mw1, wb1, cmd1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] cnd, input logic [3:0] op, input logic [1:0] md,
                           input logic s, input logic mul);
    in_valid = 1'b1; cond = cnd; op_code = op; mode = md; S_in = s; is_mul = mul;
  endtask

  localparam logic [9:0] AddWord = 10'b10_0001_0010;
  localparam logic [9:0] MulWord = 10'b10_0001_1010;

  initial begin
    rst = 1'b0; in_valid = 1'b0; cond = 4'hE; op_code = 4'h0; mode = 2'b00;
    S_in = 1'b0; is_mul = 1'b0; status = 4'h0; freeze = 1'b0; flush = 1'b0;

    vecs[0]  = mk(1'b1, 4'hE, 4'hD, 2'b00, 1'b1, 4'h0, 10'b1100010001);  // MOV S
    vecs[1]  = mk(1'b1, 4'hE, 4'hF, 2'b00, 1'b0, 4'h0, 10'b1000011001);  // MVN
    vecs[2]  = mk(1'b1, 4'hE, 4'h4, 2'b00, 1'b1, 4'h0, 10'b1100010010);  // ADD S
    vecs[3]  = mk(1'b1, 4'hE, 4'h4, 2'b01, 1'b1, 4'h0, 10'b1001010010);  // LDR
    vecs[4]  = mk(1'b1, 4'hE, 4'h4, 2'b01, 1'b0, 4'h0, 10'b1000100010);  // STR
    vecs[5]  = mk(1'b1, 4'hE, 4'h5, 2'b00, 1'b0, 4'h0, 10'b1000010011);  // ADC
    vecs[6]  = mk(1'b1, 4'hE, 4'h2, 2'b00, 1'b0, 4'h0, 10'b1000010100);  // SUB
    vecs[7]  = mk(1'b1, 4'hE, 4'h6, 2'b00, 1'b0, 4'h0, 10'b1000010101);  // SBC
    vecs[8]  = mk(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 4'h0, 10'b1000010110);  // AND
    vecs[9]  = mk(1'b1, 4'hE, 4'hC, 2'b00, 1'b0, 4'h0, 10'b1000010111);  // ORR
    vecs[10] = mk(1'b1, 4'hE, 4'h1, 2'b00, 1'b0, 4'h0, 10'b1000011000);  // EOR
    vecs[11] = mk(1'b1, 4'hE, 4'hA, 2'b00, 1'b1, 4'h0, 10'b1100000100);  // CMP
    vecs[12] = mk(1'b1, 4'hE, 4'h8, 2'b00, 1'b1, 4'h0, 10'b1100000110);  // TST
    vecs[13] = mk(1'b1, 4'hE, 4'h0, 2'b10, 1'b1, 4'h0, 10'b1010000000);  // B, op[3]=0
    vecs[14] = mk(1'b1, 4'hE, 4'h8, 2'b10, 1'b1, 4'h0, 10'b1000000000);  // B, op[3]=1
    vecs[15] = mk(1'b1, 4'hE, 4'h3, 2'b00, 1'b0, 4'h0, 10'b1000000000);  // unlisted
    vecs[16] = mk(1'b1, 4'h1, 4'h2, 2'b00, 1'b0, 4'h4, 10'b0000000000);  // NE, Z=1
    vecs[17] = mk(1'b1, 4'h0, 4'h2, 2'b00, 1'b0, 4'h4, 10'b1000010100);  // EQ, Z=1
    vecs[18] = mk(1'b1, 4'hC, 4'h4, 2'b00, 1'b0, 4'h8, 10'b0000000000);  // GT, N!=V
    vecs[19] = mk(1'b1, 4'hF, 4'h4, 2'b00, 1'b0, 4'h0, 10'b0000000000);  // never
    vecs[20] = mk(1'b0, 4'hE, 4'h4, 2'b00, 1'b0, 4'h0, 10'b0000000000);  // not valid
    vecs[21] = mk(1'b1, 4'h8, 4'h4, 2'b00, 1'b0, 4'h2, 10'b1000010010);  // HI pass
    vecs[22] = mk(1'b1, 4'hB, 4'h4, 2'b00, 1'b0, 4'h8, 10'b1000010010);  // LT pass
    vecs[23] = mk(1'b1, 4'hE, 4'hD, 2'b01, 1'b1, 4'h0, 10'b1000010001);  // MOV mode 01
    vecs[24] = mk(1'b1, 4'hD, 4'h4, 2'b00, 1'b0, 4'h1, 10'b1000010010);  // LE pass
    vecs[25] = mk(1'b1, 4'h9, 4'h4, 2'b00, 1'b0, 4'h2, 10'b0000000000);  // LS fail

    // Reset state
    #2;
    check("reset_word", {22'd0, word1()}, 32'd0);
    check("reset_busy", {31'd0, busy1}, 32'd0);
    #6 rst = 1'b1;

    // First instruction after release
    set_instr(4'hE, 4'h4, 2'b00, 1'b0, 1'b0);
    tick();
    check("add_after_reset", {22'd0, word1()}, {22'd0, AddWord});
    check("add_cmd_w6", {26'd0, cmd2}, 32'h02);

    // Decode and condition table
    for (int i = 0; i < 26; i++) begin
      in_valid = vecs[i].iv; cond = vecs[i].cnd; op_code = vecs[i].op;
      mode = vecs[i].md; S_in = vecs[i].s; is_mul = 1'b0; status = vecs[i].st;
      tick();
      check($sformatf("vec%0d", i), {22'd0, word1()}, {22'd0, vecs[i].exp});
    end
    status = 4'h0;

    // MUL, MUL_LAT=3: issue, two busy bubbles, then held ADD
    set_instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b1);
    tick();
    check("mul_issue", {22'd0, word1()}, {22'd0, MulWord});
    check("mul_busy0", {31'd0, busy1}, 32'd1);
    set_instr(4'hE, 4'h4, 2'b00, 1'b0, 1'b0);
    tick();
    check("mul_bubble1", {22'd0, word1()}, 32'd0);
    check("mul_busy1", {31'd0, busy1}, 32'd1);
    tick();
    check("mul_bubble2", {22'd0, word1()}, 32'd0);
    check("mul_busy2", {31'd0, busy1}, 32'd0);
    tick();
    check("mul_next_add", {22'd0, word1()}, {22'd0, AddWord});

    // Failed-condition MUL stays idle
    set_instr(4'h0, 4'h0, 2'b00, 1'b0, 1'b1);
    tick();
    check("mul_fail_word", {22'd0, word1()}, 32'd0);
    check("mul_fail_busy", {31'd0, busy1}, 32'd0);

    // Freeze during busy holds the MUL word and extends busy by two cycles
    set_instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b1);
    tick();
    set_instr(4'hE, 4'h4, 2'b00, 1'b0, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("frz_word%0d", i), {22'd0, word1()}, {22'd0, MulWord});
      check($sformatf("frz_busy%0d", i), {31'd0, busy1}, 32'd1);
    end
    freeze = 1'b0;
    tick();
    check("frz_after_busy", {31'd0, busy1}, 32'd1);
    check("frz_after_word", {22'd0, word1()}, 32'd0);
    tick();
    check("frz_end_busy", {31'd0, busy1}, 32'd0);
    tick();
    check("frz_add", {22'd0, word1()}, {22'd0, AddWord});

    // Flush beats freeze and clears busy
    set_instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b1);
    tick();
    set_instr(4'hE, 4'h4, 2'b00, 1'b0, 1'b0);
    freeze = 1'b1; flush = 1'b1;
    tick();
    check("flush_word", {22'd0, word1()}, 32'd0);
    check("flush_busy", {31'd0, busy1}, 32'd0);
    freeze = 1'b0; flush = 1'b0;
    tick();
    check("flush_add", {22'd0, word1()}, {22'd0, AddWord});

    // Asynchronous reset mid-cycle while busy
    set_instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b1);
    tick();
    #3 rst = 1'b0;
    #1;
    check("arst_word", {22'd0, word1()}, 32'd0);
    check("arst_busy", {31'd0, busy1}, 32'd0);
    #1 rst = 1'b1;
    set_instr(4'hE, 4'h4, 2'b00, 1'b0, 1'b0);
    tick();
    check("arst_add", {22'd0, word1()}, {22'd0, AddWord});

    // MUL_LAT=1, CMD_W=6: back-to-back MULs, never busy
    set_instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("l1_mul%0d", i), {24'd0, ov2, wb2, cmd2}, {24'd0, 2'b11, 6'b001010});
      check($sformatf("l1_busy%0d", i), {31'd0, busy2}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
